// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction memory: fetch address/word layout, NOP word,
// default geometry and the loader state encoding.
package instr_mem_pkg;

  localparam int BANKS_DEF = 2;
  localparam int WORDS_DEF = 16;

  // Opcode NOP0 with a zero immediate; also the power-up and in-load read value.
  localparam logic [7:0] NOP_WORD = 8'h80;

  typedef struct packed {
    logic       mode;
    logic [3:0] addr;
  } virt_addr_t;

  typedef struct packed {
    virt_addr_t virt_addr;
  } addr_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] imm;
  } data_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

endpackage

// File: rtl/instr_mem_if.sv
// CPU fetch port plus program-load handshake of the instruction memory.
// master = CPU/loader side, slave = instr_mem.
interface instr_mem_if;
  import instr_mem_pkg::*;

  addr_t       addr;
  data_t       data;
  logic        load_start;
  logic        load_abort;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;
  logic [7:0]  checksum;

  modport master (
    output addr, load_start, load_abort, load_data, load_valid,
    input  data, load_ready, load_done, cpu_hold, checksum
  );

  modport slave (
    input  addr, load_start, load_abort, load_data, load_valid,
    output data, load_ready, load_done, cpu_hold, checksum
  );

endinterface

// File: rtl/instr_mem_loader.sv
// Program-load controller: IDLE/LOAD FSM, write pointer and optional checksum.
// Define INSTR_MEM_CHECKSUM_EN to build the running mod-256 checksum.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter  int DEPTH = BANKS_DEF * WORDS_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_abort,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  output logic          cpu_hold,
  output logic          load_done,
  output logic [7:0]    checksum,
  output logic          wr_en,
  output logic [AW-1:0] wr_ptr,
  output logic [7:0]    wr_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  load_state_e   state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic          last_byte;
  logic          start_load;

  assign last_byte  = (ptr_q == LAST);
  assign start_load = (state_q == IDLE) && load_start;
  assign load_ready = (state_q == LOAD);
  assign cpu_hold   = (state_q == LOAD);
  assign wr_ptr     = ptr_q;
  assign wr_data    = load_data;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (load_start) state_d = LOAD;
      LOAD: begin
        // Abort takes priority and suppresses the write offered in that cycle.
        if (load_abort) begin
          state_d = IDLE;
        end else if (load_valid) begin
          wr_en = 1'b1;
          if (last_byte) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      load_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_done <= wr_en && last_byte;
      if (start_load)  ptr_q <= '0;
      else if (wr_en)  ptr_q <= last_byte ? '0 : ptr_q + AW'(1);
    end
  end

`ifdef INSTR_MEM_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           sum_q <= '0;
    else if (start_load)  sum_q <= '0;
    else if (wr_en)       sum_q <= sum_q + load_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: rtl/instr_mem.sv
// Instruction memory: BANKS*WORDS byte array with zero-latency fetch port and a
// byte-stream program loader. Optional checksum: INSTR_MEM_CHECKSUM_EN.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int BANKS = BANKS_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic clock,
  input  logic reset,
  instr_mem_if.slave bus
);

  localparam int DEPTH = BANKS * WORDS;
  localparam int AW    = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    wr_data;
  logic          hold;
  logic [AW-1:0] rd_idx;
  logic [7:0]    mem [DEPTH];

  instr_mem_loader #(.DEPTH(DEPTH)) u_loader (
    .clock      (clock),
    .reset      (reset),
    .load_start (bus.load_start),
    .load_abort (bus.load_abort),
    .load_valid (bus.load_valid),
    .load_data  (bus.load_data),
    .load_ready (bus.load_ready),
    .cpu_hold   (hold),
    .load_done  (bus.load_done),
    .checksum   (bus.checksum),
    .wr_en      (wr_en),
    .wr_ptr     (wr_ptr),
    .wr_data    (wr_data)
  );

  assign bus.cpu_hold = hold;
  assign rd_idx       = AW'({bus.addr.virt_addr.mode, bus.addr.virt_addr.addr});

  // NOTE: the array is deliberately reset (every word to NOP) so a CPU released
  // from hold never fetches stale code; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // The CPU samples this on the same edge, so the read path stays combinational.
  always_comb begin
    bus.data = data_t'(NOP_WORD);
    if (!hold) bus.data = data_t'(mem[rd_idx]);
  end

endmodule

// File: tb/tb_instr_mem.sv
// Randomized self-checking bench for instr_mem against an array/queue-level
// model of the program load (memory image, load pointer, running sum).
module tb_instr_mem;
  import instr_mem_pkg::*;

  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  instr_mem_if bus ();

  instr_mem #(.BANKS(2), .WORDS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: memory image and load progress as plain variables.
  logic [7:0] mem_m [DEPTH];
  int         ptr_m;
  logic [7:0] sum_m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_checksum();
`ifdef INSTR_MEM_CHECKSUM_EN
    return sum_m;
`else
    return 8'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP_WORD;
    ptr_m = 0;
    sum_m = 8'h00;
  endtask

  task automatic sweep(input string tag);
    logic [4:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      a = 5'(i);
      bus.addr = addr_t'(a);
      #1;
      check(tag, bus.data, mem_m[i]);
    end
  endtask

  // Checks made every cycle the DUT is expected to be in LOAD.
  task automatic busy_checks();
    bus.addr = addr_t'(5'($urandom));
    #1;
    check("load_ready_busy", bus.load_ready, 1'b1);
    check("cpu_hold_busy",   bus.cpu_hold,   1'b1);
    check("load_done_busy",  bus.load_done,  1'b0);
    check("data_nop_busy",   bus.data,       NOP_WORD);
  endtask

  // end_kind: 0 = complete (n_bytes must be DEPTH), 1 = abort, 2 = reset.
  // dmode: 0 = base+i, 1 = constant base, 2 = random.
  task automatic run_load(input int n_bytes, input int gap_before, input int restart_before,
                          input int end_kind, input int dmode, input logic [7:0] base,
                          input bit rnd_gaps);
    logic [7:0] b;
    int gaps;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    ptr_m = 0;
    sum_m = 8'h00;
    for (int i = 0; i < n_bytes; i++) begin
      gaps = (i == gap_before) ? 3 : (rnd_gaps ? int'($urandom_range(0, 2)) : 0);
      if (i == restart_before && gaps == 0) gaps = 1;
      for (int g = 0; g < gaps; g++) begin
        bus.load_valid = 1'b0;
        bus.load_data  = 8'($urandom);
        bus.load_start = (i == restart_before) && (g == 0);
        busy_checks();
        step();
      end
      bus.load_start = 1'b0;
      case (dmode)
        0:       b = base + 8'(i);
        1:       b = base;
        default: b = 8'($urandom);
      endcase
      bus.load_valid = 1'b1;
      bus.load_data  = b;
      busy_checks();
      step();
      mem_m[ptr_m] = b;
      ptr_m++;
      sum_m += b;
    end
    bus.load_valid = 1'b0;
    case (end_kind)
      0: begin
        check("load_done_pulse", bus.load_done,  1'b1);
        check("cpu_hold_after",  bus.cpu_hold,   1'b0);
        check("load_ready_after",bus.load_ready, 1'b0);
        check("checksum_done",   bus.checksum,   exp_checksum());
        step();
        check("load_done_once",  bus.load_done,  1'b0);
        check("checksum_hold",   bus.checksum,   exp_checksum());
      end
      1: begin
        bus.load_abort = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h5A;
        #1;
        check("cpu_hold_pre_abort", bus.cpu_hold, 1'b1);
        step();
        bus.load_abort = 1'b0;
        bus.load_valid = 1'b0;
        check("cpu_hold_abort",  bus.cpu_hold,  1'b0);
        check("load_done_abort", bus.load_done, 1'b0);
        check("checksum_abort",  bus.checksum,  exp_checksum());
        step();
        check("load_done_abort2", bus.load_done, 1'b0);
      end
      default: begin
        reset = 1'b0;
        #1;
        model_reset();
        check("cpu_hold_rst",   bus.cpu_hold,   1'b0);
        check("load_ready_rst", bus.load_ready, 1'b0);
        check("load_done_rst",  bus.load_done,  1'b0);
        check("checksum_rst",   bus.checksum,   exp_checksum());
        step();
        step();
        reset = 1'b1;
      end
    endcase
  endtask

  initial begin
    bus.addr       = addr_t'(5'd0);
    bus.load_start = 1'b0;
    bus.load_abort = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_valid = 1'b0;
    model_reset();

    // Power-up reset: all words NOP, outputs idle.
    #2 reset = 1'b0;
    #1;
    check("reset_cpu_hold",   bus.cpu_hold,   1'b0);
    check("reset_load_ready", bus.load_ready, 1'b0);
    check("reset_load_done",  bus.load_done,  1'b0);
    check("reset_checksum",   bus.checksum,   8'h00);
    sweep("sweep_in_reset");
    step();
    reset = 1'b1;
    step();
    sweep("sweep_after_reset");

    // Full gapless load of 0x00..0x1F.
    run_load(DEPTH, -1, -1, 0, 0, 8'h00, 1'b0);
    sweep("sweep_load_inc");
    bus.addr = addr_t'(5'h13);
    #1;
    check("word_1_3", bus.data, 8'h13);

    // Random full load with random gaps, then the same 0..1F load with a
    // three-cycle gap between bytes 5 and 6.
    run_load(DEPTH, -1, -1, 0, 2, 8'h00, 1'b1);
    sweep("sweep_load_rnd");
    run_load(DEPTH, 6, -1, 0, 0, 8'h00, 1'b0);
    sweep("sweep_load_gap");

    // Abort after ten bytes of 0xAA: earlier image must survive above word 9.
    run_load(10, -1, -1, 1, 1, 8'hAA, 1'b0);
    sweep("sweep_abort");

    // Abort in IDLE does nothing.
    bus.load_abort = 1'b1;
    step();
    bus.load_abort = 1'b0;
    check("idle_abort_hold", bus.cpu_hold, 1'b0);
    sweep("sweep_idle_abort");

    // Start and abort together in IDLE: start wins; then abort the empty load.
    bus.load_start = 1'b1;
    bus.load_abort = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.load_abort = 1'b0;
    check("start_wins_hold", bus.cpu_hold, 1'b1);
    sum_m = 8'h00;
    bus.load_abort = 1'b1;
    step();
    bus.load_abort = 1'b0;
    check("start_wins_abort", bus.cpu_hold,  1'b0);
    check("start_wins_done",  bus.load_done, 1'b0);
    check("start_wins_sum",   bus.checksum,  exp_checksum());
    sweep("sweep_start_abort");

    // Second load_start mid-load must not rewind the pointer.
    run_load(DEPTH, -1, 12, 0, 2, 8'h00, 1'b0);
    sweep("sweep_restart");

    // Reset after seven bytes discards everything.
    run_load(7, -1, -1, 2, 2, 8'h00, 1'b0);
    step();
    sweep("sweep_mid_reset");

    // A few random complete or aborted loads.
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 0) run_load(DEPTH, -1, -1, 0, 2, 8'h00, 1'b1);
      else run_load(int'($urandom_range(0, DEPTH - 1)), -1, -1, 1, 2, 8'h00, 1'b1);
      sweep("sweep_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter BANKS, default 2: number of 16-word banks, selected by addr.virt_addr.mode.
REQ-002 SHALL have parameter WORDS, default 16: words per bank, indexed by addr.virt_addr.addr.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  input  addr_t  fetch address driven by the CPU: mode bit plus 4-bit addr.
REQ-006 SHALL have port data  output  data_t  instruction word returned to the CPU: opcode[7:4], imm[3:0].
REQ-007 SHALL have port load_start  input  1  one-cycle request to begin a full program load.
REQ-008 SHALL have port load_abort  input  1  terminates a load in progress.
REQ-009 SHALL have port load_data  input  8  program byte offered.
REQ-010 SHALL have port load_valid  input  1  load_data is valid.
REQ-011 SHALL have port load_ready  output  1  a byte is accepted this cycle when load_valid is also high.
REQ-012 SHALL have port load_done  output  1  one-cycle pulse after the final byte is written.
REQ-013 SHALL have port cpu_hold  output  1  high while loading; the integration uses it to hold the CPU in reset.
REQ-014 SHALL have port checksum  output  8  mod-256 sum of the bytes accepted in the last load.

Function
REQ-015 SHALL store BANKS*WORDS bytes, indexed by the 5-bit value {mode, addr}.
REQ-016 SHALL drive data combinationally in IDLE as mem[{mode,addr}], with zero cycle latency, so the CPU samples it on the same edge.
REQ-017 SHALL drive data as NOP_WORD (0x80: opcode NOP0, imm 0) in LOAD, whatever addr is.
REQ-018 SHALL implement an FSM with states IDLE and LOAD.
REQ-019 IDLE to LOAD: on load_start; write pointer cleared to 0, checksum cleared to 0.
REQ-020 SHALL hold load_ready and cpu_hold at 1 in LOAD and at 0 in IDLE.
REQ-021 In LOAD, when load_valid and load_ready are both high, SHALL write mem[ptr] <= load_data and increment ptr by 1.
REQ-022 When the byte at ptr = BANKS*WORDS-1 is accepted, SHALL return to IDLE, pulse load_done on the next cycle only, and wrap ptr to 0.
REQ-023 SHALL ignore load_start in LOAD.
REQ-024 load_abort in LOAD: SHALL return to IDLE the next cycle with no load_done pulse and no write that cycle, even if load_valid is high; words already written SHALL be kept.
REQ-025 load_abort in IDLE: SHALL have no effect.
REQ-026 load_start and load_abort in the same IDLE cycle: load_start SHALL win.
REQ-027 SHALL ignore load_data when load_valid is low; gaps between bytes are allowed.

Reset
REQ-028 While reset is low, SHALL immediately set FSM=IDLE, ptr=0, load_done=0, checksum=0, and every memory word=NOP_WORD.
REQ-029 Reset asserted mid-load SHALL discard the partial load; all words SHALL read NOP_WORD after reset.

Configuration
REQ-030 With INSTR_MEM_CHECKSUM_EN defined, checksum SHALL add every accepted byte mod 256 and hold its value in IDLE until the next load_start.
REQ-031 Without INSTR_MEM_CHECKSUM_EN, checksum SHALL be tied to 0 and the adder SHALL not be built.

Structure
REQ-032 NOP_WORD, BANKS/WORDS defaults and the FSM state enum SHALL live in the shared types header alongside addr_t and data_t.
REQ-033 The FSM, pointer and checksum SHALL be one sub-module, instr_mem_loader; the storage array and read mux SHALL stay in instr_mem.

Verification
REQ-034 Reset low, then high, then sweep all 32 {mode,addr} -> data = 0x80 at every address.
REQ-035 load_start, then 32 bytes 0x00..0x1F with no gaps -> load_ready high for 32 cycles, load_done pulses once, then {1,0x3} reads 0x13; with EN checksum = 0xF0.
REQ-036 Load with load_valid low for 3 cycles between bytes 5 and 6 -> no extra writes; final contents identical to the no-gap load.
REQ-037 load_abort after 10 bytes (0xAA) -> IDLE, no load_done; words 0-9 read 0xAA, words 10-31 keep their previous values.
REQ-038 Reset low after 7 bytes -> cpu_hold = 0 immediately; all words read 0x80.
REQ-039 In LOAD with addr={0,0x2} -> data = 0x80; a second load_start mid-load -> ptr is not reset.
